// File: rtl/hex_7seg_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver; the displayed value swaps only on frame boundaries.
// Build macro LEADING_ZERO_BLANK_EN: blank leading zero digits of the display register (digit 0 always shown).
module hex_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark while it and every digit above it are zero; digit 0 is exempt.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] val);
    logic [NUM_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run  = run & (val[4*k +: 4] == 4'h0);
      m[k] = run;
    end
    return m;
  endfunction
`endif

  logic [DIV_W-1:0]          div_cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   staging;
  logic [4*NUM_DIGITS-1:0]   display;
  logic                      pending;
  logic                      bnd_p0;
  logic [6:0]                seg_p1;
  logic [NUM_DIGITS-1:0]     an_p1;
  logic [IDX_W-1:0]          idx_p1;
  logic                      frame_p1;

  logic                      slot_end;
  logic                      boundary;
  logic [NUM_DIGITS-1:0]     blank_vec;
  logic [3:0]                cur_nib;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     an_raw;
  logic [6:0]                seg_raw;

  always_comb begin
    slot_end = (div_cnt == DIV_LAST);
    boundary = slot_end && (idx == IDX_LAST);
`ifdef LEADING_ZERO_BLANK_EN
    blank_vec = i_blank_mask | lead_zero_mask(display);
`else
    blank_vec = i_blank_mask;
`endif
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    an_raw    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = display[4*k +: 4];
        cur_blank = blank_vec[k];
        an_raw[k] = 1'b1;
      end
    end
    seg_raw = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
  end

  // Stage p0: slot/frame sequencing and frame-synchronous value transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt <= '0;
      idx     <= '0;
      pending <= 1'b0;
      staging <= '0;
      display <= '0;
      bnd_p0  <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (i_load)
        staging <= i_value;
      // Transfer uses the staging content from before this edge, even if a load coincides
      if (boundary && pending)
        display <= staging;
      pending <= i_load | (pending & ~boundary);
      bnd_p0  <= boundary;
    end
  end

  // Stage p1: registered pin drivers, polarity applied last
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seg_p1   <= SEG_OFF;
      an_p1    <= AN_OFF;
      idx_p1   <= '0;
      frame_p1 <= 1'b0;
    end else begin
      seg_p1   <= seg_raw ^ SEG_OFF;
      an_p1    <= an_raw ^ AN_OFF;
      idx_p1   <= idx;
      frame_p1 <= bnd_p0;
    end
  end

  assign o_seg        = seg_p1;
  assign o_an         = an_p1;
  assign o_digit_idx  = idx_p1;
  assign o_frame_done = frame_p1;

endmodule

// File: tb/tb_hex_7seg_scan_driver.sv
// Bench for hex_7seg_scan_driver: cycle-count reference model plus literal checks of the display scenarios.
module tb_hex_7seg_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int FR = N * R;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  didx;
  logic        fd;

  logic [3:0]  value1;
  logic [0:0]  mask1;
  logic [6:0]  seg1;
  logic [0:0]  an1;
  logic [0:0]  didx1;
  logic        fd1;

  hex_7seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut4 (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_blank_mask(mask),
    .o_seg(seg), .o_an(an), .o_digit_idx(didx), .o_frame_done(fd)
  );

  hex_7seg_scan_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_value(value1), .i_load(load), .i_blank_mask(mask1),
    .o_seg(seg1), .o_an(an1), .o_digit_idx(didx1), .o_frame_done(fd1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0] an_walk  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] swap_seg [4] = '{7'h47, 7'h6D, 7'h77, 7'h30};
`ifdef LEADING_ZERO_BLANK_EN
  logic [6:0] lz50_seg [4] = '{7'h7E, 7'h5B, 7'h00, 7'h00};
  logic [6:0] lz00_seg [4] = '{7'h7E, 7'h00, 7'h00, 7'h00};
`else
  logic [6:0] lz50_seg [4] = '{7'h7E, 7'h5B, 7'h7E, 7'h7E};
  logic [6:0] lz00_seg [4] = '{7'h7E, 7'h7E, 7'h7E, 7'h7E};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Digit d is dark by the leading-zero rule when it is not digit 0 and nothing at or above it is set.
  function automatic bit lz_blank(input logic [15:0] v, input int d);
    return LZ && (d > 0) && ((v >> (4 * d)) == 16'h0);
  endfunction

  // Reference model: c = clock edges since reset release; slot/frame position follow from c by division.
  int          c = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_stage, m_disp;
  bit          m_pend;
  logic [6:0]  e_seg, e_seg1;
  logic [3:0]  e_an;
  logic [1:0]  e_idx;
  bit          e_fd, e_fd1;
  logic [0:0]  e_an1;

  always @(posedge clk) begin
    int d;
    bit bnd;
    bit blank;
    m_valid = 1'b1;
    if (rst) begin
      c = 0; m_stage = '0; m_disp = '0; m_pend = 1'b0;
      e_seg = 7'h00; e_an = 4'hF; e_idx = 2'd0; e_fd = 1'b0;
      e_seg1 = 7'h7F; e_an1 = 1'b1; e_fd1 = 1'b0;
    end else begin
      d     = (c / R) % N;
      bnd   = ((c + 1) % FR) == 0;
      blank = mask[d] | lz_blank(m_disp, d);
      e_seg = blank ? 7'h00 : seg_tab[m_disp[4*d +: 4]];
      e_an  = ~(4'b0001 << d);
      e_idx = d[1:0];
      e_fd  = (c > 0) && ((c % FR) == 0);
      e_seg1 = 7'h01; e_an1 = 1'b0; e_fd1 = (c > 0);
      if (bnd && m_pend) m_disp = m_stage;
      m_pend = load || (m_pend && !bnd);
      if (load) m_stage = value;
      c++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", seg, e_seg);
      check("an", an, e_an);
      check("idx", didx, e_idx);
      check("frame_done", fd, e_fd);
      check("n1_seg", seg1, e_seg1);
      check("n1_an", an1, e_an1);
      check("n1_idx", didx1, 0);
      check("n1_frame_done", fd1, e_fd1);
    end
  end

  task automatic wait_c(input int t);
    while (c < t) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    int d;
    rst = 1'b1; load = 1'b0; value = '0; mask = '0; value1 = '0; mask1 = '0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h00);
    check("rst_fd", fd, 0);
    check("rst_n1_an", an1, 1);
    check("rst_n1_seg", seg1, 7'h7F);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("walk_an", an, an_walk[k/4]);
      check("walk_seg", seg, 7'h7E);
    end
    check("n1_lit_an", an1, 0);
    check("n1_lit_seg", seg1, 7'h01);
    check("n1_lit_fd", fd1, 1);

    wait_c(25);
    do_load(16'h1A2F);
    fd_cnt = 0;
    for (int e = 25; e < 48; e++) begin
      wait_c(e + 1);
      if (e < 32) check("swap_hold", seg, 7'h7E);
      else begin
        check("swap_new", seg, swap_seg[(e-32)/4]);
        if (fd) fd_cnt++;
        if (e == 32) check("swap_fd_first", fd, 1);
      end
    end
    check("fd_once_per_frame", fd_cnt, 1);

    wait_c(52);
    do_load(16'h1111);
    wait_c(63);
    do_load(16'h2222);
    for (int e = 64; e < 96; e++) begin
      wait_c(e + 1);
      if (e < 80) check("coinc_first", seg, 7'h30);
      else check("coinc_second", seg, 7'h6D);
    end

    wait_c(96);
    do_load(16'h8888);
    mask = 4'b0100;
    for (int e = 112; e < 128; e++) begin
      wait_c(e + 1);
      if (((e / 4) % 4) == 2) begin
        check("blank_an", an, 4'hB);
        check("blank_seg", seg, 7'h00);
      end else check("unblank_seg", seg, 7'h7F);
    end
    mask = 4'b0000;

    wait_c(130);
    do_load(16'h0050);
    wait_c(146);
    do_load(16'h0000);
    for (int e = 144; e < 176; e++) begin
      wait_c(e + 1);
      d = (e / 4) % 4;
      if (e < 160) check("lz_0050", seg, lz50_seg[d]);
      else check("lz_0000", seg, lz00_seg[d]);
    end

    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 249) == 0);
      load  = ($urandom_range(0, 9) == 0);
      value = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    rst = 1'b0; load = 1'b0; mask = 4'h0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
